// File: rtl/dbus_wbuf_bridge_if.sv
// CPU data-bus and external-memory signal bundle for the write-buffered bridge.
// The bridge attaches through the slave modport; the CPU/memory environment uses master.
interface dbus_wbuf_bridge_if;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_address;
    logic [31:0] cpu_data_wr;
    logic [3:0]  cpu_mask;
    logic [31:0] cpu_data_rd;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_read, cpu_write, cpu_address, cpu_data_wr, cpu_mask,
        input  mem_ack, mem_rdata,
        output cpu_data_rd, cpu_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output cpu_read, cpu_write, cpu_address, cpu_data_wr, cpu_mask,
        output mem_ack, mem_rdata,
        input  cpu_data_rd, cpu_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/dbus_wbuf_bridge.sv
// Data-bus bridge with a posted-write FIFO: stores retire with zero stall while
// space remains, and loads wait until every older store has reached memory.
module dbus_wbuf_bridge #(
    parameter int WBUF_DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    dbus_wbuf_bridge_if.slave bus_if
);
    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, RD_WAIT, RD_DONE} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, tail_q, head_nxt;
    logic [29:0]      buf_addr_q [WBUF_DEPTH];
    logic [31:0]      buf_data_q [WBUF_DEPTH];
    logic [3:0]       buf_mask_q [WBUF_DEPTH];
    logic [31:0]      rd_buf_q;
    logic             mem_req_q, mem_we_q;
    logic [31:0]      mem_addr_q, mem_wdata_q;
    logic [3:0]       mem_be_q;

    logic             full, load_req, push, pop, ack_valid, fwd;
    logic [29:0]      entry_addr;
    logic [31:0]      entry_data;
    logic [3:0]       entry_mask;
    logic [31:0]      rd_addr;

    assign load_req  = bus_if.cpu_read & ~bus_if.cpu_write;
    assign full      = (count_q == CNT_W'(WBUF_DEPTH));
    assign push      = bus_if.cpu_write & ~full;
    assign ack_valid = bus_if.mem_ack & mem_req_q;
    assign pop       = ack_valid & (state_q == DRAIN);
    assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    assign head_nxt  = head_q + PTR_W'(1);
    assign rd_addr   = bus_if.cpu_address & 32'hFFFF_FFFC;

    // While draining, the next write is the entry behind the one being popped,
    // which can be the store arriving in this same cycle.
    assign fwd = (state_q == DRAIN) & push & (head_nxt == tail_q);

    always_comb begin
        entry_addr = buf_addr_q[head_q];
        entry_data = buf_data_q[head_q];
        entry_mask = buf_mask_q[head_q];
        if (fwd) begin
            entry_addr = bus_if.cpu_address[31:2];
            entry_data = bus_if.cpu_data_wr;
            entry_mask = bus_if.cpu_mask;
        end else if (state_q == DRAIN) begin
            entry_addr = buf_addr_q[head_nxt];
            entry_data = buf_data_q[head_nxt];
            entry_mask = buf_mask_q[head_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr_q[tail_q] <= bus_if.cpu_address[31:2];
            buf_data_q[tail_q] <= bus_if.cpu_data_wr;
            buf_mask_q[tail_q] <= bus_if.cpu_mask;
        end
    end

    // Full-stall looks only at the registered count, so a pop in this cycle
    // frees the slot for the following cycle.
    assign bus_if.cpu_stall = ~rst & ((bus_if.cpu_write & full) |
                                      (load_req & (state_q != RD_DONE)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            rd_buf_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            count_q <= count_d;
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop)  head_q <= head_nxt;
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_q     <= DRAIN;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {entry_addr, 2'b00};
                        mem_wdata_q <= entry_data;
                        mem_be_q    <= entry_mask;
                    end else if (load_req) begin
                        state_q    <= RD_WAIT;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= rd_addr;
                        mem_be_q   <= 4'b1111;
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        if (count_d != '0) begin
                            mem_addr_q  <= {entry_addr, 2'b00};
                            mem_wdata_q <= entry_data;
                            mem_be_q    <= entry_mask;
                        end else if (load_req) begin
                            state_q    <= RD_WAIT;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= rd_addr;
                            mem_be_q   <= 4'b1111;
                        end else begin
                            state_q   <= IDLE;
                            mem_req_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                        end
                    end
                end
                RD_WAIT: begin
                    if (ack_valid) begin
                        rd_buf_q  <= bus_if.mem_rdata;
                        mem_req_q <= 1'b0;
                        state_q   <= RD_DONE;
                    end
                end
                RD_DONE: begin
                    if (count_q != '0) begin
                        state_q     <= DRAIN;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {entry_addr, 2'b00};
                        mem_wdata_q <= entry_data;
                        mem_be_q    <= entry_mask;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_if.cpu_data_rd = rd_buf_q;
    assign bus_if.mem_req     = mem_req_q;
    assign bus_if.mem_we      = mem_we_q;
    assign bus_if.mem_addr    = mem_addr_q;
    assign bus_if.mem_wdata   = mem_wdata_q;
    assign bus_if.mem_be      = mem_be_q;
endmodule

// File: tb/tb_dbus_wbuf_bridge.sv
// Bench for dbus_wbuf_bridge: a CPU driver, a memory responder with its own
// byte-addressed model, and a scoreboard of expected memory transactions.
module tb_dbus_wbuf_bridge;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    int   ackDelay = 1;
    bit   ackEnable = 1'b1;
    bit   strayAck = 1'b0;
    int   reqAge = 0;
    bit   inTxn = 1'b0;
    logic [31:0] latchAddr, latchWdata;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;
    txn_t sbQ[$];

    typedef struct {
        logic        isWrite;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        int          ackDelay;
        int          expStall;
        logic [31:0] expRdata;
        logic        drainAfter;
    } vec_t;
    localparam int NV = 9;
    vec_t vecs[NV];

    logic [31:0] memModel [logic [31:0]];

    dbus_wbuf_bridge_if bus();

    dbus_wbuf_bridge #(.WBUF_DEPTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory side: completes the front scoreboard entry on each acknowledge.
    task automatic serviceTxn();
        txn_t e;
        logic [31:0] w;
        if (sbQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpectedTxn actual=%h expected=none", bus.mem_addr);
            return;
        end
        e = sbQ.pop_front();
        checkOutput("memWe", {31'b0, bus.mem_we}, {31'b0, e.we});
        checkOutput("memAddr", bus.mem_addr, e.addr);
        checkOutput("memBe", {28'b0, bus.mem_be}, {28'b0, e.be});
        w = memModel.exists(bus.mem_addr) ? memModel[bus.mem_addr] : 32'h0;
        if (e.we) begin
            checkOutput("memWdata", bus.mem_wdata, e.wdata);
            for (int b = 0; b < 4; b++)
                if (bus.mem_be[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
            memModel[bus.mem_addr] = w;
        end else begin
            bus.mem_rdata = w;
        end
    endtask

    always @(negedge clk) begin
        bus.mem_ack = 1'b0;
        if (rst) begin
            reqAge = 0;
            inTxn  = 1'b0;
        end else if (strayAck) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'hFFFF_FFFF;
        end else if (bus.mem_req) begin
            if (!inTxn) begin
                inTxn      = 1'b1;
                latchAddr  = bus.mem_addr;
                latchWdata = bus.mem_wdata;
            end else begin
                checkOutput("memAddrStable", bus.mem_addr, latchAddr);
                checkOutput("memWdataStable", bus.mem_wdata, latchWdata);
            end
            if (ackEnable) begin
                reqAge++;
                if (reqAge >= ackDelay) begin
                    bus.mem_ack = 1'b1;
                    reqAge = 0;
                    inTxn  = 1'b0;
                    serviceTxn();
                end
            end
        end else begin
            reqAge = 0;
            inTxn  = 1'b0;
        end
    end

    task automatic applyStimulus(input logic isWrite, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] mask, output int stallCycles, output logic [31:0] rdata);
        @(negedge clk);
        bus.cpu_write   = isWrite;
        bus.cpu_read    = ~isWrite;
        bus.cpu_address = addr;
        bus.cpu_data_wr = data;
        bus.cpu_mask    = mask;
        if (!isWrite) sbQ.push_back('{1'b0, {addr[31:2], 2'b00}, 32'h0, 4'hF});
        stallCycles = 0;
        #1;
        while (bus.cpu_stall && stallCycles < 200) begin
            stallCycles++;
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        if (bus.cpu_stall) begin
            checks++;
            failures++;
            $display("[TB] FAIL stallTimeout actual=%0d expected=<200", stallCycles);
        end
        rdata = bus.cpu_data_rd;
        if (isWrite) sbQ.push_back('{1'b1, {addr[31:2], 2'b00}, data, mask});
        @(posedge clk);
        #1;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((bus.mem_req || sbQ.size() != 0) && n < 300);
        checkOutput("drainIdle", {31'b0, bus.mem_req}, 32'h0);
        checkOutput("sbEmpty", 32'(sbQ.size()), 32'h0);
    endtask

    task automatic idleCycles(input int n, input string name);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            checkOutput(name, {31'b0, bus.mem_req}, 32'h0);
        end
    endtask

    initial begin
        int          stall;
        logic [31:0] rd;

        vecs[0] = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 2, 0, 32'h0, 1'b1};
        vecs[1] = '{1'b1, 32'h0000_0200, 32'hCAFE_F00D, 4'hF, 2, 0, 32'h0, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0200, 32'h0,         4'h0, 2, 5, 32'hCAFE_F00D, 1'b1};
        vecs[3] = '{1'b0, 32'h0000_0303, 32'h0,         4'h0, 3, 4, 32'h1122_3344, 1'b1};
        vecs[4] = '{1'b1, 32'h0000_0204, 32'h1234_5678, 4'h3, 1, 0, 32'h0, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0205, 32'hAABB_CCDD, 4'h4, 1, 0, 32'h0, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_0206, 32'h0,         4'h0, 1, -1, 32'h00BB_5678, 1'b1};
        vecs[7] = '{1'b1, 32'h0000_0010, 32'h0102_0304, 4'hF, 4, 0, 32'h0, 1'b0};
        vecs[8] = '{1'b0, 32'h0000_0012, 32'h0,         4'h0, 4, -1, 32'h0102_0304, 1'b1};
        memModel[32'h0000_0300] = 32'h1122_3344;

        rst             = 1'b1;
        bus.cpu_read    = 1'b0;
        bus.cpu_write   = 1'b0;
        bus.cpu_address = '0;
        bus.cpu_data_wr = '0;
        bus.cpu_mask    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstMemReq", {31'b0, bus.mem_req}, 32'h0);
        checkOutput("rstMemWe", {31'b0, bus.mem_we}, 32'h0);
        checkOutput("rstMemAddr", bus.mem_addr, 32'h0);
        checkOutput("rstMemBe", {28'b0, bus.mem_be}, 32'h0);
        checkOutput("rstStall", {31'b0, bus.cpu_stall}, 32'h0);
        checkOutput("rstDataRd", bus.cpu_data_rd, 32'h0);
        #1 rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            ackDelay = vecs[i].ackDelay;
            applyStimulus(vecs[i].isWrite, vecs[i].addr, vecs[i].data, vecs[i].mask, stall, rd);
            if (vecs[i].expStall >= 0) checkOutput("stallCycles", 32'(stall), 32'(vecs[i].expStall));
            if (!vecs[i].isWrite) checkOutput("loadData", rd, vecs[i].expRdata);
            if (vecs[i].drainAfter) waitDrain();
        end
        idleCycles(2, "idleAfterTable");

        // Fill the buffer with acks withheld; the fifth store must wait for a pop.
        ackEnable = 1'b0;
        ackDelay  = 1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, stall, rd);
            checkOutput("fillStall", 32'(stall), 32'h0);
        end
        @(negedge clk);
        bus.cpu_write   = 1'b1;
        bus.cpu_address = 32'h1010;
        bus.cpu_data_wr = 32'hA000_0004;
        bus.cpu_mask    = 4'hF;
        #1;
        checkOutput("fullStall", {31'b0, bus.cpu_stall}, 32'h1);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            checkOutput("fullStallHold", {31'b0, bus.cpu_stall}, 32'h1);
        end
        ackEnable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("stallOnPopCycle", {31'b0, bus.cpu_stall}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("stallReleased", {31'b0, bus.cpu_stall}, 32'h0);
        sbQ.push_back('{1'b1, 32'h1010, 32'hA000_0004, 4'hF});
        @(posedge clk);
        #1 bus.cpu_write = 1'b0;
        waitDrain();

        // Reset in the middle of a read, then a stray acknowledge.
        ackEnable = 1'b0;
        @(negedge clk);
        bus.cpu_read    = 1'b1;
        bus.cpu_address = 32'h400;
        sbQ.push_back('{1'b0, 32'h400, 32'h0, 4'hF});
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rdWaitReq", {31'b0, bus.mem_req}, 32'h1);
        checkOutput("rdWaitWe", {31'b0, bus.mem_we}, 32'h0);
        rst = 1'b1;
        bus.cpu_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rstRdReq", {31'b0, bus.mem_req}, 32'h0);
        checkOutput("rstRdData", bus.cpu_data_rd, 32'h0);
        rst = 1'b0;
        sbQ.delete();
        strayAck = 1'b1;
        @(negedge clk);
        #1 strayAck = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("strayAckData", bus.cpu_data_rd, 32'h0);
        checkOutput("strayAckReq", {31'b0, bus.mem_req}, 32'h0);

        // Reset while three stores are buffered and draining.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 32'h2000 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF, stall, rd);
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("drainReq", {31'b0, bus.mem_req}, 32'h1);
        checkOutput("drainWe", {31'b0, bus.mem_we}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rstDrainReq", {31'b0, bus.mem_req}, 32'h0);
        rst = 1'b0;
        sbQ.delete();
        ackEnable = 1'b1;
        strayAck  = 1'b1;
        @(negedge clk);
        #1 strayAck = 1'b0;
        idleCycles(4, "postRstIdle");
        checkOutput("postRstData", bus.cpu_data_rd, 32'h0);

        ackDelay = 2;
        applyStimulus(1'b1, 32'h500, 32'h55AA_55AA, 4'hF, stall, rd);
        checkOutput("postRstStoreStall", 32'(stall), 32'h0);
        applyStimulus(1'b0, 32'h500, 32'h0, 4'h0, stall, rd);
        checkOutput("postRstLoad", rd, 32'h55AA_55AA);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
